// File: rtl/cpu_mem_bridge_if.sv
// CPU-side instruction/data channels plus the single-port SRAM bus of the bridge.
// The bridge connects through the slave modport; the CPU/SRAM side uses master.
interface cpu_mem_bridge_if #(
  parameter int MEM_AW = 14
);
  logic [31:0]       PC;
  logic              Inst_Req_Valid;
  logic              Inst_Req_Ack;
  logic [31:0]       Instruction;
  logic              Inst_Valid;
  logic              Inst_Ack;
  logic [31:0]       Address;
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       Write_data;
  logic [3:0]        Write_strb;
  logic              Mem_Req_Ack;
  logic [31:0]       Read_data;
  logic              Read_data_Valid;
  logic              Read_data_Ack;
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ack, Address, MemRead, MemWrite,
           Write_data, Write_strb, Read_data_Ack, mem_rdata,
    output Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data,
           Read_data_Valid, mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output PC, Inst_Req_Valid, Inst_Ack, Address, MemRead, MemWrite,
           Write_data, Write_strb, Read_data_Ack, mem_rdata,
    input  Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data,
           Read_data_Valid, mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Serialises the CPU instruction and data channels onto one synchronous single-port SRAM.
// Optional BRIDGE_PERF_CNT_EN adds fetch/load/store accept counters as extra ports.
module cpu_mem_bridge #(
  parameter int MEM_AW = 14,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  cpu_mem_bridge_if.slave bus
`ifdef BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_load_cnt,
  output logic [31:0] perf_store_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, I_WAIT, I_RESP, D_WAIT, D_RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic [1:0]        lat_cnt;
  logic [31:0]       inst_q, rdata_q;
  logic              fetch_acc, load_acc, store_acc;
  logic              mem_en, lat_done;
  logic [3:0]        mem_wen;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              unused_ok;

  assign lat_done = (lat_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
      inst_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (fetch_acc || load_acc)
        lat_cnt <= LAT_INIT;
      else if ((state == I_WAIT || state == D_WAIT) && !lat_done)
        lat_cnt <= lat_cnt - 2'd1;
      if (state == I_WAIT && lat_done)
        inst_q <= bus.mem_rdata;
      if (state == D_WAIT && lat_done)
        rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    fetch_acc = 1'b0;
    load_acc  = 1'b0;
    store_acc = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = 4'd0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        // Stores complete in the accept cycle; reads park in a WAIT state.
        if (!rst) begin
          if (bus.MemWrite) begin
            store_acc = 1'b1;
            mem_en    = 1'b1;
            mem_wen   = bus.Write_strb;
            mem_addr  = bus.Address[MEM_AW+1:2];
            mem_wdata = bus.Write_data;
          end else if (bus.MemRead) begin
            load_acc  = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = bus.Address[MEM_AW+1:2];
            state_nxt = D_WAIT;
          end else if (bus.Inst_Req_Valid) begin
            fetch_acc = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = bus.PC[MEM_AW+1:2];
            state_nxt = I_WAIT;
          end
        end
      end
      I_WAIT:  if (lat_done) state_nxt = I_RESP;
      I_RESP:  if (bus.Inst_Ack) state_nxt = IDLE;
      D_WAIT:  if (lat_done) state_nxt = D_RESP;
      D_RESP:  if (bus.Read_data_Ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Inst_Req_Ack    = fetch_acc;
  assign bus.Mem_Req_Ack     = load_acc | store_acc;
  assign bus.Inst_Valid      = (state == I_RESP);
  assign bus.Read_data_Valid = (state == D_RESP);
  assign bus.Instruction     = inst_q;
  assign bus.Read_data       = rdata_q;
  assign bus.mem_en          = mem_en;
  assign bus.mem_wen         = mem_wen;
  assign bus.mem_addr        = mem_addr;
  assign bus.mem_wdata       = mem_wdata;

  // Byte-offset and above-window address bits are deliberately ignored (aliasing).
  assign unused_ok = ^{bus.PC[31:MEM_AW+2], bus.PC[1:0],
                       bus.Address[31:MEM_AW+2], bus.Address[1:0]};

`ifdef BRIDGE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_load_cnt  <= 32'd0;
      perf_store_cnt <= 32'd0;
    end else begin
      if (fetch_acc) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (load_acc)  perf_load_cnt  <= perf_load_cnt + 32'd1;
      if (store_acc) perf_store_cnt <= perf_store_cnt + 32'd1;
    end
  end
`endif

endmodule
